seg_scan_driver: RTL and testbench

- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display.
- Sits directly downstream of the alarm/timer counter: takes four BCD digits (digit 0 = seconds units … digit 3 = minutes tens) and produces active-low segment and anode drive.
- Adds frame-coherent digit capture, anti-ghost anode blanking, optional leading-zero suppression and whole-display blinking for alarm indication.

---
 rtl/seg_pkg.sv | 18 +
 rtl/bcd_to_seg.sv | 24 ++
 rtl/seg_scan_driver.sv | 70 +++++++
 tb/tb_seg_scan_driver.sv | 112 +++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment patterns and display constants for the seven-segment scan driver.
package seg_pkg;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam int         NUM_DIGITS = 4;
    typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit common-anode scan driver with frame-coherent capture,
// anti-ghost blanking, leading-zero suppression and blink gating; all outputs registered.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_BITS = 17,
    parameter int BLINK_BITS   = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bin0,
    input  logic [3:0] bin1,
    input  logic [3:0] bin2,
    input  logic [3:0] bin3,
    input  logic       blink_en,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic [3:0] AN,
    output logic       dp
);
    logic [REFRESH_BITS-1:0]      r_scan;
    logic [BLINK_BITS-1:0]        r_blink;
    digit_idx_t                   r_idx;
    logic [NUM_DIGITS-1:0][3:0]   r_dig;
    logic [6:0]                   r_seg;
    logic [3:0]                   r_an;
    logic                         r_dp;
    logic                         w_slot_end;
    logic                         w_lz;
    logic                         w_blank;
    logic [3:0]                   w_an;
    logic [6:0]                   w_seg;

    assign w_slot_end = &r_scan;
    assign w_lz       = lz_blank && r_dig[3] == 4'd0 && r_idx == 2'd3;
    assign w_blank    = blink_en && !r_blink[BLINK_BITS-1];
    // first clock of each slot keeps anodes off so the segment change never ghosts
    assign w_an       = (r_scan == '0 || w_lz || w_blank) ? AN_OFF : ~(4'b0001 << r_idx);

    bcd_to_seg u_dec (
        .i_bcd (r_dig[r_idx]),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scan  <= '0;
            r_blink <= '0;
            r_idx   <= '0;
            r_dig   <= '0;
            r_seg   <= SEG_OFF;
            r_an    <= AN_OFF;
            r_dp    <= 1'b1;
        end else begin
            r_scan  <= r_scan + REFRESH_BITS'(1);
            r_blink <= r_blink + BLINK_BITS'(1);
            if (w_slot_end)
                r_idx <= r_idx + 2'd1;
            if (w_slot_end && r_idx == 2'd3)
                r_dig <= {bin3, bin2, bin1, bin0};
            r_seg   <= w_seg;
            r_an    <= w_an;
            r_dp    <= w_an[2];
        end
    end

    assign seg = r_seg;
    assign AN  = r_an;
    assign dp  = r_dp;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench; expected pin states are queued per frame and popped one per clock.
module tb_seg_scan_driver;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] bin0 = '0, bin1 = '0, bin2 = '0, bin3 = '0;
    logic       blink_en = 1'b0, lz_blank = 1'b0;
    logic [6:0] seg;
    logic [3:0] AN;
    logic       dp;
    logic [11:0] q[$];
    int total = 0;
    int bad = 0;
    localparam logic [11:0] RST_VAL = {4'b1111, 7'b1111111, 1'b1};
    localparam logic [6:0] PAT [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                         7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_BITS(2), .BLINK_BITS(4)) dut (
        .clk(clk), .reset(reset), .bin0(bin0), .bin1(bin1), .bin2(bin2), .bin3(bin3),
        .blink_en(blink_en), .lz_blank(lz_blank), .seg(seg), .AN(AN), .dp(dp)
    );

    function automatic logic [6:0] pat(input logic [3:0] v);
        return (v > 4'd9) ? 7'b0111111 : PAT[v];
    endfunction

    // one frame = 4 slots x 4 clocks; entries before blink_n that fall in the blink-off half are dark
    task automatic push_frame(input logic [3:0] d3, d2, d1, d0, input logic lz, input int blink_n);
        logic [3:0] d [4];
        logic [3:0] an;
        int s;
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 16; i++) begin
            s = i / 4;
            an = 4'b1111;
            if (i % 4 != 0 && !(lz && s == 3 && d3 == 4'd0) && !(i < blink_n && i < 8))
                an[s] = 1'b0;
            q.push_back({an, pat(d[s]), an[2]});
        end
    endtask

    task automatic check(input string tag, input logic [11:0] exp);
        total++;
        assert ({AN, seg, dp} === exp) else begin
            bad++;
            $error("FAIL %s: got AN=%b seg=%b dp=%b, expected AN=%b seg=%b dp=%b",
                   tag, AN, seg, dp, exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s: scoreboard empty, got AN=%b seg=%b dp=%b", tag, AN, seg, dp);
            end else
                check(tag, q.pop_front());
        end
    endtask

    initial begin
        bin3 = 4'd1; bin2 = 4'd2; bin1 = 4'd3; bin0 = 4'd4;
        repeat (3) q.push_back(RST_VAL);
        run(3, "reset_hold");
        reset = 1'b1;
        check("reset_release", RST_VAL);
        push_frame(0, 0, 0, 0, 1'b0, 0);
        run(16, "first_frame_zeros");
        push_frame(1, 2, 3, 4, 1'b0, 0);
        run(16, "digits_1234");
        push_frame(1, 2, 3, 4, 1'b0, 0);
        run(6, "no_tear");
        bin0 = 4'd7;
        run(10, "no_tear");
        bin3 = 4'd0;
        push_frame(1, 2, 3, 7, 1'b0, 0);
        run(16, "new_digit0");
        lz_blank = 1'b1;
        push_frame(0, 2, 3, 7, 1'b1, 0);
        run(16, "lz_blank_on");
        lz_blank = 1'b0;
        bin0 = 4'd12;
        push_frame(0, 2, 3, 7, 1'b0, 0);
        run(16, "lz_blank_off");
        push_frame(0, 2, 3, 12, 1'b0, 0);
        run(16, "dash");
        blink_en = 1'b1;
        push_frame(0, 2, 3, 12, 1'b0, 16);
        run(16, "blink");
        push_frame(0, 2, 3, 12, 1'b0, 3);
        run(3, "blink_stop");
        blink_en = 1'b0;
        run(13, "blink_stop");
        push_frame(0, 2, 3, 12, 1'b0, 0);
        run(9, "pre_reset");
        q.delete();
        reset = 1'b0;
        q.push_back(RST_VAL);
        run(1, "reset_mid_slot");
        reset = 1'b1;
        push_frame(0, 0, 0, 0, 1'b0, 0);
        run(16, "post_reset_zeros");
        push_frame(0, 2, 3, 12, 1'b0, 0);
        run(16, "post_reset_capture");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
